// File: rtl/radar_pass_scheduler_if.sv
// rtl/radar_pass_scheduler_if.sv - signal bundle between the PS/reader side and radar_pass_scheduler
// master: PS/reader side; drives s_entry_data/s_entry_valid, rdr_sts_data, clr_flags
// slave : scheduler side; drives s_entry_ready, rdr_cfg_data, pass_strobe, entry_done,
//         sts_level, sts_pass, sts_flags
interface radar_pass_scheduler_if #(
  parameter int QUEUE_DEPTH = 4,
  parameter int CFG_WIDTH   = 16,
  parameter int REP_WIDTH   = 16
);
  localparam int LVL_W = $clog2(QUEUE_DEPTH) + 1;

  logic [CFG_WIDTH+REP_WIDTH-1:0] s_entry_data;
  logic                           s_entry_valid;
  logic                           s_entry_ready;
  logic [CFG_WIDTH-1:0]           rdr_cfg_data;
  logic [CFG_WIDTH-1:0]           rdr_sts_data;
  logic                           pass_strobe;
  logic                           entry_done;
  logic [LVL_W-1:0]               sts_level;
  logic [REP_WIDTH-1:0]           sts_pass;
  logic [1:0]                     sts_flags;
  logic                           clr_flags;

  modport master (
    output s_entry_data, s_entry_valid, rdr_sts_data, clr_flags,
    input  s_entry_ready, rdr_cfg_data, pass_strobe, entry_done,
           sts_level, sts_pass, sts_flags
  );

  modport slave (
    input  s_entry_data, s_entry_valid, rdr_sts_data, clr_flags,
    output s_entry_ready, rdr_cfg_data, pass_strobe, entry_done,
           sts_level, sts_pass, sts_flags
  );
endinterface

// File: rtl/radar_pass_scheduler.sv
// rtl/radar_pass_scheduler.sv - chooses the waveform cfg the radar RAM reader plays on each pass
// aclk, areset    : clock, asynchronous active-high reset
// bus.s_entry_*   : entry push {repeats, reader cfg}; repeats 0 = forever
// bus.rdr_cfg_data: cfg word to reader ([15:14] quarter, [13:0] last burst index)
// bus.rdr_sts_data: reader status address, used to detect pass starts
// bus.pass_strobe : pulse per detected pass start
// bus.entry_done  : pulse when the successor entry is loaded
// bus.sts_level   : queued entries (active entry excluded)
// bus.sts_pass    : passes started on the active entry
// bus.sts_flags   : [0] sticky underrun, [1] sticky rejected entry; bus.clr_flags clears
module radar_pass_scheduler #(
  parameter int QUEUE_DEPTH = 4,
  parameter int CFG_WIDTH   = 16,
  parameter int REP_WIDTH   = 16
) (
  input  logic                   aclk,
  input  logic                   areset,
  radar_pass_scheduler_if.slave  bus
);
  localparam int IDX_W = CFG_WIDTH - 2;
  localparam int PTR_W = $clog2(QUEUE_DEPTH);
  localparam int LVL_W = PTR_W + 1;
  localparam int ENT_W = CFG_WIDTH + REP_WIDTH;

  typedef enum logic {ST_IDLE, ST_RUN} state_t;

  state_t               state_q, state_d;
  logic [ENT_W-1:0]     queue_q [QUEUE_DEPTH];
  logic [ENT_W-1:0]     queue_d [QUEUE_DEPTH];
  logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0]     level_q, level_d;
  logic                 ready_q, ready_d;
  logic [CFG_WIDTH-1:0] cfg_q, cfg_d;
  logic [REP_WIDTH-1:0] rep_q, rep_d;
  logic [REP_WIDTH-1:0] pass_q, pass_d;
  logic                 fresh_q, fresh_d;
  logic [IDX_W-1:0]     prev_q, prev_d;
  logic                 strobe_q, strobe_d;
  logic                 done_q, done_d;
  logic [1:0]           flags_q, flags_d;

  logic [CFG_WIDTH-1:0] entry_cfg;
  logic [REP_WIDTH-1:0] entry_rep;
  logic [ENT_W-1:0]     head;
  logic                 push_fire, pass_start, at_final, pop_ok, enq, deq;
  logic [REP_WIDTH-1:0] new_pass, rep_last;
  logic                 unused_sts_quarter;

  assign entry_cfg = bus.s_entry_data[CFG_WIDTH-1:0];
  assign entry_rep = bus.s_entry_data[ENT_W-1:CFG_WIDTH];
  assign head      = queue_q[rd_ptr_q];
  assign push_fire = bus.s_entry_valid && ready_q;

  // Only the index field wraps; the quarter bits play no part in pass detection.
  assign pass_start = (bus.rdr_sts_data[IDX_W-1:0] == '0) && (prev_q != '0);
  assign unused_sts_quarter = ^bus.rdr_sts_data[CFG_WIDTH-1:IDX_W];

  // The first start after a cfg change is the reader still finishing the old cfg,
  // so it counts as pass 0 of the new entry rather than incrementing.
  assign new_pass = fresh_q ? '0 : ((pass_q == '1) ? pass_q : pass_q + REP_WIDTH'(1));
  assign rep_last = rep_q - REP_WIDTH'(1);
  // ">=" keeps a starved entry eligible for a pop on every later start.
  assign at_final = (rep_q != '0) && (new_pass >= rep_last);
  assign pop_ok   = (rep_q == '0) || at_final;

  always_comb begin
    state_d  = state_q;
    queue_d  = queue_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    cfg_d    = cfg_q;
    rep_d    = rep_q;
    pass_d   = pass_q;
    fresh_d  = fresh_q;
    prev_d   = bus.rdr_sts_data[IDX_W-1:0];
    strobe_d = pass_start;
    done_d   = 1'b0;
    flags_d  = bus.clr_flags ? 2'b00 : flags_q;
    enq      = 1'b0;
    deq      = 1'b0;

    if (push_fire) begin
      if (entry_cfg[IDX_W-1:0] == '0) begin
        flags_d[1] = 1'b1;
      end else if (state_q == ST_IDLE) begin
        cfg_d   = entry_cfg;
        rep_d   = entry_rep;
        pass_d  = '0;
        fresh_d = 1'b1;
        state_d = ST_RUN;
      end else begin
        enq = 1'b1;
      end
    end

    if ((state_q == ST_RUN) && pass_start) begin
      pass_d  = new_pass;
      fresh_d = 1'b0;
      if (pop_ok && (level_q != '0)) begin
        deq     = 1'b1;
        cfg_d   = head[CFG_WIDTH-1:0];
        rep_d   = head[ENT_W-1:CFG_WIDTH];
        pass_d  = '0;
        fresh_d = 1'b1;
        done_d  = 1'b1;
      end else if ((rep_q != '0) && (new_pass == rep_last)) begin
        flags_d[0] = 1'b1;
      end
    end

    if (enq) begin
      queue_d[wr_ptr_q] = bus.s_entry_data;
      wr_ptr_d          = wr_ptr_q + PTR_W'(1);
    end
    if (deq) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    if (enq && !deq) begin
      level_d = level_q + LVL_W'(1);
    end else if (!enq && deq) begin
      level_d = level_q - LVL_W'(1);
    end
    ready_d = (level_d != LVL_W'(QUEUE_DEPTH));
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state_q  <= ST_IDLE;
      for (int i = 0; i < QUEUE_DEPTH; i++) begin
        queue_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      ready_q  <= 1'b0;
      cfg_q    <= '0;
      rep_q    <= '0;
      pass_q   <= '0;
      fresh_q  <= 1'b0;
      prev_q   <= '0;
      strobe_q <= 1'b0;
      done_q   <= 1'b0;
      flags_q  <= 2'b00;
    end else begin
      state_q  <= state_d;
      queue_q  <= queue_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      ready_q  <= ready_d;
      cfg_q    <= cfg_d;
      rep_q    <= rep_d;
      pass_q   <= pass_d;
      fresh_q  <= fresh_d;
      prev_q   <= prev_d;
      strobe_q <= strobe_d;
      done_q   <= done_d;
      flags_q  <= flags_d;
    end
  end

  assign bus.s_entry_ready = ready_q;
  assign bus.rdr_cfg_data  = cfg_q;
  assign bus.pass_strobe   = strobe_q;
  assign bus.entry_done    = done_q;
  assign bus.sts_level     = level_q;
  assign bus.sts_pass      = pass_q;
  assign bus.sts_flags     = flags_q;
endmodule

// File: tb/tb_radar_pass_scheduler.sv
// tb/tb_radar_pass_scheduler.sv - directed self-checking bench for radar_pass_scheduler
module tb_radar_pass_scheduler;
  logic aclk;
  logic areset;

  radar_pass_scheduler_if #(.QUEUE_DEPTH(4), .CFG_WIDTH(16), .REP_WIDTH(16)) bus ();

  radar_pass_scheduler #(.QUEUE_DEPTH(4), .CFG_WIDTH(16), .REP_WIDTH(16)) dut (
    .aclk   (aclk),
    .areset (areset),
    .bus    (bus)
  );

  initial begin
    aclk = 1'b0;
    forever #5 aclk = ~aclk;
  end

  int          n_total;
  int          n_pass;
  int          n_fail;
  int          strobe_cnt;
  int          done_cnt;
  int          base_s;
  int          base_d;
  logic [15:0] last_cfg;
  logic [15:0] sb [$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock; outputs are sampled 1 time unit after the active edge.
  // Every cfg change seen on the reader port is matched against the scoreboard.
  task automatic tick();
    @(posedge aclk);
    #1;
    if (bus.pass_strobe) strobe_cnt++;
    if (bus.entry_done) done_cnt++;
    if (!areset && (bus.rdr_cfg_data !== last_cfg)) begin
      if (sb.size() == 0) chk("cfg_unexpected", 32'(bus.rdr_cfg_data), 32'(last_cfg));
      else chk("cfg_sb", 32'(bus.rdr_cfg_data), 32'(sb.pop_front()));
      last_cfg = bus.rdr_cfg_data;
    end
  endtask

  task automatic do_reset();
    areset            = 1'b1;
    bus.s_entry_valid = 1'b0;
    bus.s_entry_data  = '0;
    bus.clr_flags     = 1'b0;
    bus.rdr_sts_data  = '0;
    sb.delete();
    tick();
    tick();
    areset   = 1'b0;
    last_cfg = bus.rdr_cfg_data;
    tick();
  endtask

  task automatic push(input logic [15:0] rep, input logic [15:0] cfg);
    if (bus.s_entry_ready && (cfg[13:0] != 14'd0)) sb.push_back(cfg);
    bus.s_entry_data  = {rep, cfg};
    bus.s_entry_valid = 1'b1;
    tick();
    bus.s_entry_valid = 1'b0;
  endtask

  task automatic set_sts(input logic [15:0] v);
    bus.rdr_sts_data = v;
    tick();
  endtask

  task automatic run_pass(input logic [1:0] q, input int last);
    for (int i = 0; i <= last; i++) set_sts({q, 14'(i)});
  endtask

  initial begin
    n_total = 0; n_pass = 0; n_fail = 0;
    strobe_cnt = 0; done_cnt = 0;
    last_cfg = '0;
    areset = 1'b1;
    bus.s_entry_valid = 1'b0;
    bus.s_entry_data  = '0;
    bus.clr_flags     = 1'b0;
    bus.rdr_sts_data  = '0;

    // Reset state
    tick();
    chk("rst_cfg",    32'(bus.rdr_cfg_data), 32'h0);
    chk("rst_level",  32'(bus.sts_level), 32'h0);
    chk("rst_flags",  32'(bus.sts_flags), 32'h0);
    chk("rst_pass",   32'(bus.sts_pass), 32'h0);
    chk("rst_strobe", 32'(bus.pass_strobe), 32'h0);
    chk("rst_done",   32'(bus.entry_done), 32'h0);
    do_reset();
    chk("rst_ready",  32'(bus.s_entry_ready), 32'h1);

    // Single entry rep=3: IDLE load, strobe timing, pass counting, underrun at final pass
    base_s = strobe_cnt;
    push(16'd3, 16'h4005);
    chk("s1_cfg_load", 32'(bus.rdr_cfg_data), 32'h4005);
    chk("s1_pass0",    32'(bus.sts_pass), 32'h0);
    run_pass(2'd1, 5);
    chk("s1_no_strobe", 32'(strobe_cnt - base_s), 32'h0);
    set_sts(16'h4000);
    chk("s1_strobe_hi", 32'(bus.pass_strobe), 32'h1);
    set_sts(16'h4001);
    chk("s1_strobe_lo", 32'(bus.pass_strobe), 32'h0);
    chk("s1_first_is_pass0", 32'(bus.sts_pass), 32'h0);
    for (int i = 2; i <= 5; i++) set_sts({2'd1, 14'(i)});
    run_pass(2'd1, 5);
    chk("s1_pass1", 32'(bus.sts_pass), 32'h1);
    chk("s1_flags_before", 32'(bus.sts_flags), 32'h0);
    run_pass(2'd1, 5);
    chk("s1_pass2",    32'(bus.sts_pass), 32'h2);
    chk("s1_underrun", 32'(bus.sts_flags), 32'h1);
    chk("s1_cfg_hold", 32'(bus.rdr_cfg_data), 32'h4005);
    chk("s1_strobes",  32'(strobe_cnt - base_s), 32'h3);
    chk("s1_sb_empty", 32'(sb.size()), 32'h0);

    // A{rep=2} then B{rep=1}: switch at A's second start; B's single pass starves
    do_reset();
    base_d = done_cnt;
    push(16'd2, 16'h0003);
    chk("s2_cfg_a", 32'(bus.rdr_cfg_data), 32'h0003);
    push(16'd1, 16'h8007);
    chk("s2_level1", 32'(bus.sts_level), 32'h1);
    run_pass(2'd0, 3);
    run_pass(2'd0, 3);
    chk("s2_cfg_still_a", 32'(bus.rdr_cfg_data), 32'h0003);
    chk("s2_level_still1", 32'(bus.sts_level), 32'h1);
    set_sts(16'h0000);
    chk("s2_cfg_b",    32'(bus.rdr_cfg_data), 32'h8007);
    chk("s2_done_hi",  32'(bus.entry_done), 32'h1);
    chk("s2_level0",   32'(bus.sts_level), 32'h0);
    chk("s2_pass_clr", 32'(bus.sts_pass), 32'h0);
    set_sts(16'h0001);
    chk("s2_done_lo",  32'(bus.entry_done), 32'h0);
    set_sts(16'h0002);
    set_sts(16'h0003);
    chk("s2_no_flag_yet", 32'(bus.sts_flags), 32'h0);
    run_pass(2'd2, 7);
    chk("s2_rep1_underrun", 32'(bus.sts_flags), 32'h1);
    chk("s2_cfg_b_hold", 32'(bus.rdr_cfg_data), 32'h8007);
    chk("s2_done_cnt", 32'(done_cnt - base_d), 32'h1);
    chk("s2_sb_empty", 32'(sb.size()), 32'h0);

    // A{rep=2} alone starves, late push C switches at next start, clear vs set
    do_reset();
    base_d = done_cnt;
    push(16'd2, 16'h0003);
    run_pass(2'd0, 3);
    run_pass(2'd0, 3);
    run_pass(2'd0, 3);
    chk("s3_underrun", 32'(bus.sts_flags), 32'h1);
    chk("s3_pass1",    32'(bus.sts_pass), 32'h1);
    chk("s3_cfg_a",    32'(bus.rdr_cfg_data), 32'h0003);
    push(16'd1, 16'h4002);
    chk("s3_level1",   32'(bus.sts_level), 32'h1);
    run_pass(2'd0, 3);
    chk("s3_cfg_c",    32'(bus.rdr_cfg_data), 32'h4002);
    chk("s3_level0",   32'(bus.sts_level), 32'h0);
    chk("s3_done_cnt", 32'(done_cnt - base_d), 32'h1);
    bus.clr_flags = 1'b1;
    set_sts(16'h4000);
    bus.clr_flags = 1'b0;
    chk("s3_set_wins", 32'(bus.sts_flags), 32'h1);
    push(16'd5, 16'h0001);
    bus.clr_flags = 1'b1;
    tick();
    bus.clr_flags = 1'b0;
    chk("s3_clr_flags", 32'(bus.sts_flags), 32'h0);
    chk("s3_clr_keeps_queue", 32'(bus.sts_level), 32'h1);

    // A{rep=0} plays forever; B pushed later takes over at the next start
    do_reset();
    base_d = done_cnt;
    push(16'd0, 16'h4002);
    for (int p = 0; p < 11; p++) run_pass(2'd1, 2);
    chk("s4_pass9",   32'(bus.sts_pass), 32'h9);
    chk("s4_noflag",  32'(bus.sts_flags), 32'h0);
    chk("s4_cfg_a",   32'(bus.rdr_cfg_data), 32'h4002);
    push(16'd1, 16'h0005);
    chk("s4_cfg_a_after_push", 32'(bus.rdr_cfg_data), 32'h4002);
    set_sts(16'h4000);
    chk("s4_cfg_b",   32'(bus.rdr_cfg_data), 32'h0005);
    chk("s4_level0",  32'(bus.sts_level), 32'h0);
    chk("s4_done",    32'(done_cnt - base_d), 32'h1);
    chk("s4_sb_empty", 32'(sb.size()), 32'h0);

    // Zero-index entry dropped; queue fills to depth 4; full queue refuses pushes
    do_reset();
    push(16'd1, 16'h0001);
    push(16'd1, 16'h4000);
    chk("s5_reject_flag", 32'(bus.sts_flags), 32'h2);
    chk("s5_reject_level", 32'(bus.sts_level), 32'h0);
    chk("s5_cfg_e1", 32'(bus.rdr_cfg_data), 32'h0001);
    push(16'd1, 16'h0002);
    push(16'd1, 16'h0003);
    push(16'd1, 16'h0004);
    chk("s5_ready_l3", 32'(bus.s_entry_ready), 32'h1);
    push(16'd1, 16'h0005);
    chk("s5_level4",   32'(bus.sts_level), 32'h4);
    chk("s5_ready_lo", 32'(bus.s_entry_ready), 32'h0);
    push(16'd1, 16'h0006);
    chk("s5_level_full_hold", 32'(bus.sts_level), 32'h4);
    chk("s5_sb_queued", 32'(sb.size()), 32'h4);

    // Asynchronous reset mid-RUN, sampled before any further clock edge
    #2 areset = 1'b1;
    #1;
    chk("s6_async_cfg",   32'(bus.rdr_cfg_data), 32'h0);
    chk("s6_async_level", 32'(bus.sts_level), 32'h0);
    chk("s6_async_flags", 32'(bus.sts_flags), 32'h0);
    do_reset();
    chk("s6_ready_after", 32'(bus.s_entry_ready), 32'h1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
